// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, one-word-line, write-through / no-write-allocate
//            data cache with blocking fills and load hit/miss statistics.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int LINES      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tags  [LINES];
    logic [DATA_WIDTH-1:0] words [LINES];
    logic                  store_done;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  is_load;
    logic                  is_store;
    logic                  fill_done;
    logic                  write_done;
    logic                  count_hit;
    logic                  count_miss;
    logic                  unused_ok;

    assign idx        = addr_i[2+IDX_W-1:2];
    assign tag        = addr_i[DATA_WIDTH-1:2+IDX_W];
    assign hit        = valid[idx] && (tags[idx] == tag);
    assign is_store   = wr_en_i;
    assign is_load    = rd_en_i && !wr_en_i;
    assign fill_done  = (state == FILL)  && mem_ack_i;
    assign write_done = (state == WRITE) && mem_ack_i;
    assign count_hit  = (state == IDLE) && is_load && hit;
    assign count_miss = (state == IDLE) && is_load && !hit;
    assign unused_ok  = &{1'b0, addr_i[1:0]};

    always_comb begin
        next_state  = state;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        data_o      = '0;
        case (state)
            IDLE: begin
                // The store just acknowledged is still on the bus this cycle;
                // it has completed, so it must not be re-issued.
                if (is_store && !store_done) begin
                    stall_o    = 1'b1;
                    next_state = WRITE;
                end else if (is_load) begin
                    if (hit) begin
                        data_o = words[idx];
                    end else begin
                        stall_o    = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_i[DATA_WIDTH-1:2], 2'b00};
                stall_o    = 1'b1;
                if (mem_ack_i) next_state = IDLE;
            end
            WRITE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {addr_i[DATA_WIDTH-1:2], 2'b00};
                mem_wdata_o = data_i;
                stall_o     = 1'b1;
                if (mem_ack_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            valid        <= '0;
            store_done   <= 1'b0;
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            state      <= next_state;
            store_done <= write_done;
            if (fill_done) valid[idx] <= 1'b1;
            if (count_hit && (hit_count_o != 16'hFFFF))
                hit_count_o <= hit_count_o + 16'd1;
            if (count_miss && (miss_count_o != 16'hFFFF))
                miss_count_o <= miss_count_o + 16'd1;
        end
    end

    // Reset forces IDLE asynchronously, so fill/write strobes cannot fire under reset.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            tags[idx]  <= tag;
            words[idx] <= mem_rdata_i;
        end else if (write_done && hit) begin
            words[idx] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Brief    : Directed self-checking bench for data_cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata_in = '0;
    logic [31:0] data_out;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          stalls;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    data_cache #(.DATA_WIDTH(32), .LINES(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_en_i      (rd_en),
        .wr_en_i      (wr_en),
        .addr_i       (addr),
        .data_i       (wdata_in),
        .data_o       (data_out),
        .stall_o      (stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; holds the request until stall drops, acking the
    // memory request on its (lat+1)-th cycle. Returns at posedge+1 with enables low.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int lat,
                          input logic [31:0] rdata, output int nstall);
        int   reqc;
        logic done;
        rd_en = rd; wr_en = wr; addr = a; wdata_in = d;
        nstall = 0; reqc = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done      = 1'b1;
                load_data = data_out;
            end else begin
                nstall++;
                if (mem_req) begin
                    reqc++;
                    req_addr  = mem_addr;
                    req_we    = mem_we;
                    req_wdata = mem_wdata;
                    if (reqc == lat + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rdata;
                    end
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        check("access_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall",   {31'd0, stall},   32'd0);
        check("rst_req",     {31'd0, mem_req}, 32'd0);
        check("rst_data",    data_out,         32'd0);
        check("rst_hits",    {16'd0, hit_count},  32'd0);
        check("rst_misses",  {16'd0, miss_count}, 32'd0);
        @(posedge clk); #1;

        // cold load
        access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, stalls);
        check("cold_stalls", stalls, 32'd5);
        check("cold_addr",   req_addr, 32'h100);
        check("cold_we",     {31'd0, req_we}, 32'd0);
        check("cold_data",   load_data, 32'hDEADBEEF);
        check("cold_misses", {16'd0, miss_count}, 32'd1);
        check("cold_hits",   {16'd0, hit_count},  32'd1);

        // reload
        access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, stalls);
        check("reload_stalls", stalls, 32'd0);
        check("reload_data",   load_data, 32'hDEADBEEF);
        check("reload_hits",   {16'd0, hit_count}, 32'd2);

        // conflict on index 0
        access(1'b1, 1'b0, 32'h120, 32'h0, 0, 32'hCAFEF00D, stalls);
        check("conf_stalls", stalls, 32'd2);
        check("conf_addr",   req_addr, 32'h120);
        check("conf_data",   load_data, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, stalls);
        check("evict_stalls", stalls, 32'd3);
        check("evict_misses", {16'd0, miss_count}, 32'd3);
        check("evict_hits",   {16'd0, hit_count},  32'd4);

        // store hit
        access(1'b0, 1'b1, 32'h100, 32'h12345678, 1, 32'h0, stalls);
        check("sthit_stalls", stalls, 32'd3);
        check("sthit_we",     {31'd0, req_we}, 32'd1);
        check("sthit_addr",   req_addr, 32'h100);
        check("sthit_wdata",  req_wdata, 32'h12345678);
        access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, stalls);
        check("sthit_reload_stalls", stalls, 32'd0);
        check("sthit_reload_data",   load_data, 32'h12345678);
        check("sthit_hits",  {16'd0, hit_count},  32'd5);
        check("sthit_misses", {16'd0, miss_count}, 32'd3);

        // store miss on the same index: no allocate, line untouched
        access(1'b0, 1'b1, 32'h203, 32'h000055AA, 0, 32'h0, stalls);
        check("stmiss_stalls", stalls, 32'd2);
        check("stmiss_addr",   req_addr, 32'h200);
        check("stmiss_wdata",  req_wdata, 32'h000055AA);
        access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, stalls);
        check("stmiss_keep_stalls", stalls, 32'd0);
        check("stmiss_keep_data",   load_data, 32'h12345678);
        access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h0BADF00D, stalls);
        check("stmiss_load_stalls", stalls, 32'd2);
        check("stmiss_load_data",   load_data, 32'h0BADF00D);
        check("stmiss_misses", {16'd0, miss_count}, 32'd4);
        check("stmiss_hits",   {16'd0, hit_count},  32'd7);

        // rd and wr together behave as a store
        access(1'b1, 1'b1, 32'h200, 32'h00000077, 0, 32'hFFFFFFFF, stalls);
        check("both_stalls", stalls, 32'd2);
        check("both_we",     {31'd0, req_we}, 32'd1);
        check("both_counts", {hit_count, miss_count}, {16'd7, 16'd4});
        access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h0, stalls);
        check("both_reload_stalls", stalls, 32'd0);
        check("both_reload_data",   load_data, 32'h00000077);

        // stray ack while idle
        mem_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_stall", {31'd0, stall},   32'd0);
        check("idle_ack_req",   {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("idle_ack_counts", {hit_count, miss_count}, {16'd8, 16'd4});

        // reset in the middle of a fill
        rd_en = 1'b1; addr = 32'h300;
        @(negedge clk);
        check("mf_stall0", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mf_req",  {31'd0, mem_req}, 32'd1);
        check("mf_data", data_out, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mf_req_cleared", {31'd0, mem_req}, 32'd0);
        check("mf_we_cleared",  {31'd0, mem_we},  32'd0);
        check("mf_counts",      {hit_count, miss_count}, 32'd0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        check("mf_late_ack_req",   {31'd0, mem_req}, 32'd0);
        check("mf_late_ack_stall", {31'd0, stall},   32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h33333333, stalls);
        check("mf_reload_stalls", stalls, 32'd2);
        check("mf_reload_data",   load_data, 32'h33333333);
        check("mf_misses", {16'd0, miss_count}, 32'd1);
        check("mf_hits",   {16'd0, hit_count},  32'd1);

        // hit counter saturation
        rd_en = 1'b1; addr = 32'h300;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_hits",  {16'd0, hit_count}, 32'h0000FFFF);
        check("sat_stall", {31'd0, stall}, 32'd0);
        rd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
